mul_pipe_arb: RTL and testbench
===============================

Name: mul_pipe_arb

Overview:
- Round-robin arbiter/scheduler sharing one pipelined FP multiplier (mul_pipe datapath, fixed latency MUL_LAT) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready and issues at most one per cycle into the multiplier.
- Tracks requester tags in a shadow shift register aligned to the multiplier stages, and routes each result plus its NV flag back to its originator.
- Stalls the whole multiplier (mul_en low) when the result at the tail cannot be delivered.

Parameters:
- SIGN_W, 1, sign width.
- EXPO_W, 8, exponent width.
- MANT_W, 23, mantissa width; operand width W = SIGN_W+EXPO_W+MANT_W.
- NREQ, 4, number of requesters (2..16).
- MUL_LAT, 3, multiplier pipeline depth in cycles (>=1).
- TAG_W, $clog2(NREQ), requester tag width (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request valid per requester.
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero.
- req_a  in  NREQ*W  operand A per requester; requester i occupies slice [i*W +: W].
- req_b  in  NREQ*W  operand B per requester, same packing.
- mul_en  out  1  multiplier stage-advance enable.
- mul_in_vld  out  1  issue slot holds a valid operation.
- mul_a  out  W  operand A to multiplier.
- mul_b  out  W  operand B to multiplier.
- mul_res  in  W  multiplier result, valid MUL_LAT advancing cycles after issue.
- mul_nv  in  1  invalid-operation flag aligned with mul_res.
- rsp_valid  out  NREQ  result valid, one-hot or zero.
- rsp_ready  in  NREQ  requester accepts result.
- rsp_data  out  W  result, shared by all requesters.
- rsp_nv  out  1  NV flag aligned with rsp_data.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (async, rst_n=0):
  - All shadow valid bits are 0.
  - RR pointer is 0.
  - Outputs: req_ready=0, mul_in_vld=0, rsp_valid=0, busy=0, mul_en=1, mul_a/mul_b=0.
- Reset asserted mid-operation drops all in-flight tags; results already in the multiplier are discarded and never responded.
- Shadow pipeline: vld[0..MUL_LAT-1] and tag[0..MUL_LAT-1].
  - Registers shift only when mul_en=1.
  - Stage 0 loads the issue decision.
  - The tail is stage MUL_LAT-1, aligned with mul_res/mul_nv.
- Stall rule: mul_en = !(vld_tail && !rsp_ready[tag_tail]). This is combinational from rsp_ready; no combinational path exists from req_valid to mul_en.
- Response:
  - rsp_valid = onehot(tag_tail) & {NREQ{vld_tail}}.
  - rsp_data = mul_res, rsp_nv = mul_nv, both driven combinationally.
  - Data is held stable while stalled because the multiplier is frozen.
- Arbitration:
  - When mul_en=1, grant the first requester with req_valid set, searching from ptr upward with wrap-around (ptr, ptr+1, …, NREQ-1, 0, …).
  - req_ready[g]=1 for the granted g only.
  - mul_in_vld=1; mul_a/mul_b are the combinational mux of requester g.
  - Stage 0 captures vld=1, tag=g.
  - ptr becomes (g+1) mod NREQ; this wraps from NREQ-1 to 0.
- No grant cases:
  - If mul_en=0, req_ready=0 and ptr holds.
  - If no request is valid, stage 0 captures vld=0 (bubble) and ptr holds.
- Simultaneous events:
  - Issue and tail delivery in the same cycle are both permitted.
  - A requester may be granted while receiving its own response.
- Back-to-back throughput is one operation per cycle when no stall occurs.
- Latency from req handshake to rsp_valid is MUL_LAT cycles plus any stall cycles.
- Handshake rules:
  - The requester holds req_a/req_b stable while req_valid=1 and req_ready=0.
  - rsp_valid stays high until rsp_ready.
- busy = |vld.

Decomposition:
- Package mul_pipe_pkg holds:
  - function onehot(tag) returning NREQ bits;
  - function w_of(SIGN_W, EXPO_W, MANT_W);
  - typedef of the shadow-stage struct {vld, tag}.
- One sub-module rr_arb #(N): inputs req[N], en, clk, rst_n; outputs gnt_oh[N], gnt_idx. It holds the pointer and updates it on grant when en=1.
- The shadow pipe, stall logic, and operand mux live in mul_pipe_arb.

Test Plan:
- Reset then single request: req_valid=0001, a=0x3F800000 (1.0), b=0x40000000 (2.0), MUL_LAT=3 -> req_ready[0] in cycle 0; rsp_valid=0001 with rsp_data=0x40000000 and rsp_nv=0 exactly 3 cycles later.
- All four requesting continuously, rsp_ready=1111 -> grants 0,1,2,3,0,1…; one result per cycle; tags match the grant order.
- rsp_ready[2]=0 when tag 2 reaches the tail, held 5 cycles -> mul_en=0 and req_ready=0 for 5 cycles; rsp_data stable; ptr unchanged; flow resumes in order after release.
- ptr=3 with req_valid=1001 -> requester 3 is granted, ptr wraps to 0, then requester 0 is granted next cycle.
- Requester 1 sends a=0x7F800000 (inf), b=0x00000000 (zero) -> rsp_nv=1 with rsp_valid=0010.
- rst_n pulsed low with 3 operations in flight -> rsp_valid=0 and busy=0 immediately; no stale responses appear after release.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_pipe_pkg                                                     |
// | Brief   : Shared types and helpers for the shared-multiplier scheduler.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mul_pipe_pkg;

  localparam int c_max_nreq  = 16;
  localparam int c_max_tag_w = 4;

  typedef struct packed {
    logic                   vld;
    logic [c_max_tag_w-1:0] tag;
  } stage_t;

  function automatic int w_of(input int sign_w, input int expo_w, input int mant_w);
    return sign_w + expo_w + mant_w;
  endfunction

  function automatic logic [c_max_nreq-1:0] onehot(input logic [c_max_tag_w-1:0] tag);
    return c_max_nreq'(1) << tag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_pipe_arb_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_arb                                                           |
// | Brief   : Round-robin arbiter; pointer advances past the winner on grant.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arb #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic             w_hit;

  // Scan offsets 0..N-1 from the pointer; the first requester found wins.
  always_comb begin
    w_hit   = 1'b0;
    w_sum   = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
      if (!w_hit && req[w_sum[IDX_W-1:0]]) begin
        w_hit   = 1'b1;
        gnt_idx = w_sum[IDX_W-1:0];
      end
    end
    gnt_oh = (en && w_hit) ? (N'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en && w_hit) begin
      r_ptr <= (gnt_idx == IDX_W'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_pipe_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_pipe_arb                                                     |
// | Brief   : Shares one pipelined FP multiplier among NREQ requesters.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_pipe_arb
  import mul_pipe_pkg::*;
#(
  parameter  int SIGN_W  = 1,
  parameter  int EXPO_W  = 8,
  parameter  int MANT_W  = 23,
  parameter  int NREQ    = 4,
  parameter  int MUL_LAT = 3,
  localparam int W       = w_of(SIGN_W, EXPO_W, MANT_W),
  localparam int TAG_W   = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic             mul_en,
  output logic             mul_in_vld,
  output logic [W-1:0]     mul_a,
  output logic [W-1:0]     mul_b,
  input  logic [W-1:0]     mul_res,
  input  logic             mul_nv,
  output logic [NREQ-1:0]  rsp_valid,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_nv,
  output logic             busy
);

  stage_t                r_stage [MUL_LAT];
  logic                  w_tail_vld;
  logic [c_max_nreq-1:0] w_tail_oh;
  logic                  w_issue_en;
  logic [NREQ-1:0]       w_gnt_oh;
  logic [TAG_W-1:0]      w_gnt_idx;

  assign w_tail_vld = r_stage[MUL_LAT-1].vld;
  assign w_tail_oh  = onehot(r_stage[MUL_LAT-1].tag);

  // Freeze when the tail owner is not ready; depends only on rsp_ready and state.
  assign mul_en    = !(w_tail_vld && ((w_tail_oh & c_max_nreq'(rsp_ready)) == '0));
  assign rsp_valid = w_tail_oh[NREQ-1:0] & {NREQ{w_tail_vld}};
  assign rsp_data  = mul_res;
  assign rsp_nv    = mul_nv;

  // No grants while reset is held, so req_ready stays low during reset.
  assign w_issue_en = mul_en & rst_n;

  rr_arb #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (w_issue_en),
    .gnt_oh  (w_gnt_oh),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready  = w_gnt_oh;
  assign mul_in_vld = |w_gnt_oh;

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_oh[i]) begin
        mul_a = req_a[i*W +: W];
        mul_b = req_b[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) r_stage[i] <= '0;
    end else if (mul_en) begin
      r_stage[0] <= '{vld: mul_in_vld, tag: c_max_tag_w'(w_gnt_idx)};
      for (int i = 1; i < MUL_LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | r_stage[i].vld;
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mul_pipe_arb                                                  |
// | Brief   : Directed self-checking bench with a behavioural 3-stage FP mul.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_pipe_arb;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 3;

  logic            clk;
  logic            rst_n;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic            mul_en, mul_in_vld, mul_nv, rsp_nv, busy;
  logic [W-1:0]    mul_a, mul_b, mul_res, rsp_data;
  logic [W:0]      r_mp [LAT];

  int n_pass  = 0;
  int n_total = 0;
  int exp_ptr = 0;

  mul_pipe_arb #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_en(mul_en), .mul_in_vld(mul_in_vld),
    .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .mul_nv(mul_nv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_nv(rsp_nv), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply; subnormals flush to zero.
  function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return {1'b0, 32'h7FC00000};
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {1'b1, 32'h7FC00000};
    if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'h0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin e = e + 1; m = p[46:24]; end
    else m = p[45:23];
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 31'h0};
    return {1'b0, s, e[7:0], m};
  endfunction

  always @(posedge clk) begin
    if (mul_en) begin
      r_mp[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) r_mp[i] <= r_mp[i-1];
    end
  end
  assign mul_res = r_mp[LAT-1][31:0];
  assign mul_nv  = r_mp[LAT-1][32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        nv;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] opa  [4];
  logic [31:0] resb [4];
  int          exp_g [14];
  int          exp_t [14];
  int          issued [12];

  initial begin
    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0};
    vecs[1] = '{1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1};
    vecs[2] = '{2, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
    vecs[3] = '{1, 32'h40400000, 32'h3F000000, 32'h3FC00000, 1'b0};
    vecs[4] = '{0, 32'hC0000000, 32'h40800000, 32'hC1000000, 1'b0};
    vecs[5] = '{3, 32'h00000000, 32'hC0000000, 32'h80000000, 1'b0};
    opa  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    resb = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
    exp_g = '{0, 1, 2, 3, 0, -1, -1, -1, -1, -1, 1, 2, 3, 0};
    exp_t = '{-1, -1, -1, 0, 1, 2, 2, 2, 2, 2, 2, 3, 0, 1};

    rst_n = 1'b0; req_valid = '0; rsp_ready = 4'hF; req_a = '0; req_b = '0;
    #3;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_mul_in_vld", 32'(mul_in_vld), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mul_en", 32'(mul_en), 32'h1);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // Single requests from the table.
    foreach (vecs[v]) begin
      tick();
      req_valid = 4'(1 << vecs[v].idx);
      req_a[vecs[v].idx*W +: W] = vecs[v].a;
      req_b[vecs[v].idx*W +: W] = vecs[v].b;
      #4;
      check($sformatf("v%0d_req_ready", v), 32'(req_ready), 32'(1 << vecs[v].idx));
      check($sformatf("v%0d_mul_a", v), mul_a, vecs[v].a);
      tick();
      req_valid = '0;
      tick(); #4;
      check($sformatf("v%0d_rsp_early", v), 32'(rsp_valid), 32'h0);
      tick(); #4;
      check($sformatf("v%0d_rsp_valid", v), 32'(rsp_valid), 32'(1 << vecs[v].idx));
      check($sformatf("v%0d_rsp_data", v), rsp_data, vecs[v].res);
      check($sformatf("v%0d_rsp_nv", v), 32'(rsp_nv), 32'(vecs[v].nv));
      exp_ptr = (vecs[v].idx + 1) % NREQ;
    end

    // All four requesting continuously.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = 32'h40000000;
    end
    tick();
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #4;
      check($sformatf("rr_c%0d_grant", c), 32'(req_ready), 32'(1 << exp_ptr));
      issued[c] = exp_ptr;
      exp_ptr = (exp_ptr + 1) % NREQ;
      if (c >= LAT) begin
        check($sformatf("rr_c%0d_rsp_valid", c), 32'(rsp_valid), 32'(1 << issued[c-LAT]));
        check($sformatf("rr_c%0d_rsp_data", c), rsp_data, resb[issued[c-LAT]]);
      end else begin
        check($sformatf("rr_c%0d_rsp_idle", c), 32'(rsp_valid), 32'h0);
      end
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Requester 2 withholds rsp_ready for 5 cycles while its result is at the tail.
    rsp_ready = 4'b1011;
    req_valid = 4'hF;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) rsp_ready = 4'hF;
      #4;
      check($sformatf("st_c%0d_req_ready", c), 32'(req_ready),
            (exp_g[c] < 0) ? 32'h0 : 32'(1 << exp_g[c]));
      check($sformatf("st_c%0d_rsp_valid", c), 32'(rsp_valid),
            (exp_t[c] < 0) ? 32'h0 : 32'(1 << exp_t[c]));
      check($sformatf("st_c%0d_mul_en", c), 32'(mul_en), (c >= 5 && c <= 9) ? 32'h0 : 32'h1);
      if (exp_t[c] >= 0) check($sformatf("st_c%0d_rsp_data", c), rsp_data, resb[exp_t[c]]);
      tick();
    end
    req_valid = '0;
    repeat (5) tick();

    // Pointer at 3 with requesters 0 and 3 pending: 3 then wrap to 0.
    req_valid = 4'b0100;
    #4; check("wrap_set_ptr", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1001;
    #4; check("wrap_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0001;
    #4; check("wrap_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // Reset with three operations in flight.
    req_valid = 4'b0111;
    #4; check("fl_grant1", 32'(req_ready), 32'h2);
    tick();
    #4; check("fl_grant2", 32'(req_ready), 32'h4);
    tick();
    #4; check("fl_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #4;
    check("fl_rsp_before_rst", 32'(rsp_valid), 32'h2);
    check("fl_busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("fl_rsp_in_rst", 32'(rsp_valid), 32'h0);
    check("fl_busy_in_rst", 32'(busy), 32'h0);
    check("fl_mul_en_in_rst", 32'(mul_en), 32'h1);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      check($sformatf("post_rst_c%0d_rsp", c), 32'(rsp_valid), 32'h0);
      check($sformatf("post_rst_c%0d_busy", c), 32'(busy), 32'h0);
      tick();
    end
    req_valid = 4'hF;
    #4; check("post_rst_ptr0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
